// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared constants and occupancy encoding for the FIFO read streamer
package fifo_rd_pkg;

  // Number of words the output skid buffer can hold
  localparam int BUF_DEPTH = 2;

  // Occupancy of the skid buffer; the encoding equals the word count
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - 2-entry in-order skid buffer with registered valid and head data
module rd_skid_buf #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_i,
  input  logic [DATAWIDTH-1:0] wr_data_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 xfer_o,
  output logic [1:0]           occ_o
);
  import fifo_rd_pkg::*;

  occ_e                 state_q;
  logic                 valid_q;
  logic [DATAWIDTH-1:0] head_q;
  logic [DATAWIDTH-1:0] tail_q;
  logic                 xfer;

  // A word leaves whenever the head is valid and downstream accepts it
  assign xfer    = valid_q & ready_i;
  assign xfer_o  = xfer;
  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign occ_o   = state_q;

  // Occupancy FSM; head_q is always the oldest word, tail_q the one behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (wr_i) begin
            head_q  <= wr_data_i;
            state_q <= OCC_ONE;
            valid_q <= 1'b1;
          end
        end
        OCC_ONE: begin
          case ({wr_i, xfer})
            2'b10: begin
              tail_q  <= wr_data_i;
              state_q <= OCC_TWO;
            end
            2'b01: begin
              state_q <= OCC_EMPTY;
              valid_q <= 1'b0;
            end
            2'b11: begin
              // The only word leaves as the new one lands, so it goes straight to the head
              head_q <= wr_data_i;
            end
            default: ;
          endcase
        end
        OCC_TWO: begin
          if (xfer) begin
            head_q <= tail_q;
            if (wr_i) begin
              tail_q <= wr_data_i;
            end else begin
              state_q <= OCC_ONE;
            end
          end
        end
        default: begin
          state_q <= OCC_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO-to-stream read adapter; optional delivered-word counter under FIFO_RD_CNT_EN
module fifo_rd_stream #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk_rd,
  input  logic                 rrst,
  input  logic                 empty,
  output logic                 O_rden,
  input  logic [DATAWIDTH-1:0] I_fifo_data,
  output logic                 O_valid,
  input  logic                 I_ready,
  output logic [DATAWIDTH-1:0] O_data
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]          O_rd_cnt
`endif
);
  import fifo_rd_pkg::*;

  logic       inflight_q;
  logic       xfer;
  logic [1:0] occ;
  logic [2:0] pending;

  // Pop only when the buffer still has room after counting the word in flight and this cycle's departure
  always_comb begin
    pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, xfer};
    O_rden  = !rrst && !empty && (pending < 3'(BUF_DEPTH));
  end

  // An accepted pop returns data on the following cycle; reset drops it
  always_ff @(posedge clk_rd or posedge rrst) begin
    if (rrst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= O_rden;
    end
  end

  rd_skid_buf #(
    .DATAWIDTH(DATAWIDTH)
  ) u_buf (
    .clk      (clk_rd),
    .rst      (rrst),
    .wr_i     (inflight_q),
    .wr_data_i(I_fifo_data),
    .ready_i  (I_ready),
    .valid_o  (O_valid),
    .data_o   (O_data),
    .xfer_o   (xfer),
    .occ_o    (occ)
  );

`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_cnt_q;

  assign O_rd_cnt = rd_cnt_q;

  // Count delivered words, wrapping naturally at 16 bits
  always_ff @(posedge clk_rd or posedge rrst) begin
    if (rrst) begin
      rd_cnt_q <= 16'd0;
    end else if (xfer) begin
      rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

  logic       clk_rd = 1'b0;
  logic       rrst;
  logic       empty;
  logic       O_rden;
  logic [7:0] I_fifo_data;
  logic       O_valid;
  logic       I_ready;
  logic [7:0] O_data;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] O_rd_cnt;
`endif

  always #5 clk_rd = ~clk_rd;

  fifo_rd_stream #(
    .DATAWIDTH(8)
  ) dut (
    .clk_rd     (clk_rd),
    .rrst       (rrst),
    .empty      (empty),
    .O_rden     (O_rden),
    .I_fifo_data(I_fifo_data),
    .O_valid    (O_valid),
    .I_ready    (I_ready),
    .O_data     (O_data)
`ifdef FIFO_RD_CNT_EN
    ,
    .O_rd_cnt   (O_rd_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       emp;
    logic       rdy;
    logic [7:0] fdata;
    logic       e_rden;
    logic       e_valid;
    logic       chk_data;
    logic [7:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic emp, input logic rdy, input logic [7:0] fdata,
                              input logic e_rden, input logic e_valid, input logic chk_data,
                              input logic [7:0] e_data);
    vec_t v;
    v.rst = rst; v.emp = emp; v.rdy = rdy; v.fdata = fdata;
    v.e_rden = e_rden; v.e_valid = e_valid; v.chk_data = chk_data; v.e_data = e_data;
    return v;
  endfunction

  vec_t vt[15];

  // Environment: FIFO contents and reference model of words held / in flight
  logic     force_empty;
  bit [7:0] fifo_q[$];
  bit [7:0] mbuf[$];
  bit [7:0] mfly[$];
  bit [7:0] gen_word;
  bit [7:0] exp_next;
  int       cyc, xfer_total, n_xfer, n_pop;
  int       first_rden, first_valid, first_xfer, last_xfer, occ_max, ready_pct;

  task automatic load(input int n);
    repeat (n) begin
      fifo_q.push_back(gen_word);
      gen_word++;
    end
  endtask

  task automatic tick();
    bit       exp_valid, exp_xfer, exp_rden, acc;
    bit [7:0] w;
    @(negedge clk_rd);
    empty = force_empty || (fifo_q.size() == 0);
    #1;
    exp_valid = mbuf.size() > 0;
    exp_xfer  = exp_valid && I_ready;
    exp_rden  = !empty && ((mbuf.size() + mfly.size() - int'(exp_xfer)) < 2);
    check("rden", 32'(O_rden), 32'(exp_rden));
    check("valid", 32'(O_valid), 32'(exp_valid));
    if (exp_valid) check("data", 32'(O_data), 32'(mbuf[0]));
    if (empty) check("no_pop_when_empty", 32'(O_rden), 32'd0);
    if (exp_xfer) begin
      check("order", 32'(O_data), 32'(exp_next));
      exp_next++;
      n_xfer++;
      xfer_total++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
    end
    if (O_rden && first_rden < 0) first_rden = cyc;
    if (O_valid && first_valid < 0) first_valid = cyc;
    if (int'(dut.u_buf.occ_o) > occ_max) occ_max = int'(dut.u_buf.occ_o);
    acc = O_rden && !empty;
    if (acc) n_pop++;
    @(posedge clk_rd);
    #1;
    if (exp_xfer) void'(mbuf.pop_front());
    if (mfly.size() > 0) mbuf.push_back(mfly.pop_front());
    if (acc && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      mfly.push_back(w);
      I_fifo_data = w;
    end else begin
      I_fifo_data = 8'($urandom);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk_rd);
    rrst = 1'b1;
    empty = 1'b0;
    force_empty = 1'b0;
    I_ready = 1'b0;
    fifo_q.delete();
    mbuf.delete();
    mfly.delete();
    #1;
    check("rst_valid", 32'(O_valid), 32'd0);
    check("rst_data", 32'(O_data), 32'd0);
    check("rst_rden", 32'(O_rden), 32'd0);
`ifdef FIFO_RD_CNT_EN
    check("rst_cnt", 32'(O_rd_cnt), 32'd0);
`endif
    @(negedge clk_rd);
    empty = 1'b1;
    rrst = 1'b0;
    exp_next = gen_word;
    xfer_total = 0; n_xfer = 0; n_pop = 0; cyc = 0;
    first_rden = -1; first_valid = -1; first_xfer = -1; last_xfer = -1;
  endtask

  initial begin
    rrst = 1'b1; empty = 1'b1; I_ready = 1'b0; I_fifo_data = 8'h00; force_empty = 1'b0;
    gen_word = 8'h01; occ_max = 0;

    // rst emp rdy fdata | rden valid chk data
    vt[0]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 8'h00);
    vt[1]  = mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
    vt[2]  = mk(0, 0, 0, 8'h01, 1, 0, 0, 8'h00);
    vt[3]  = mk(0, 0, 0, 8'h02, 0, 1, 1, 8'h01);
    vt[4]  = mk(0, 0, 0, 8'hEE, 0, 1, 1, 8'h01);
    vt[5]  = mk(0, 0, 1, 8'hEE, 1, 1, 1, 8'h01);
    vt[6]  = mk(0, 0, 1, 8'h03, 1, 1, 1, 8'h02);
    vt[7]  = mk(0, 1, 1, 8'h04, 0, 1, 1, 8'h03);
    vt[8]  = mk(0, 1, 0, 8'hEE, 0, 1, 1, 8'h04);
    vt[9]  = mk(0, 1, 1, 8'hEE, 0, 1, 1, 8'h04);
    vt[10] = mk(0, 1, 1, 8'hEE, 0, 0, 0, 8'h00);
    vt[11] = mk(0, 0, 1, 8'hEE, 1, 0, 0, 8'h00);
    vt[12] = mk(1, 0, 1, 8'h05, 0, 0, 1, 8'h00);
    vt[13] = mk(0, 1, 1, 8'h05, 0, 0, 1, 8'h00);
    vt[14] = mk(0, 1, 1, 8'h05, 0, 0, 1, 8'h00);

    repeat (2) @(posedge clk_rd);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_rd);
      rrst = vt[i].rst; empty = vt[i].emp; I_ready = vt[i].rdy; I_fifo_data = vt[i].fdata;
      #1;
      check($sformatf("vec%0d_rden", i), 32'(O_rden), 32'(vt[i].e_rden));
      check($sformatf("vec%0d_valid", i), 32'(O_valid), 32'(vt[i].e_valid));
      if (vt[i].chk_data) check($sformatf("vec%0d_data", i), 32'(O_data), 32'(vt[i].e_data));
    end

    // Streaming: 0x01..0x10 with downstream always ready
    gen_word = 8'h01;
    do_reset();
    load(16);
    I_ready = 1'b1;
    repeat (24) tick();
    check("stream_first_rden", 32'(first_rden), 32'd0);
    check("stream_latency", 32'(first_valid - first_rden), 32'd2);
    check("stream_count", 32'(n_xfer), 32'd16);
    check("stream_back_to_back", 32'(last_xfer - first_xfer), 32'd15);
    check("stream_last", 32'(exp_next), 32'h11);

    // Back-pressure: four words, downstream stalled, then released
    gen_word = 8'h01;
    do_reset();
    load(4);
    I_ready = 1'b0;
    repeat (6) tick();
    check("bp_pops", 32'(n_pop), 32'd2);
    check("bp_hold_data", 32'(O_data), 32'h01);
    check("bp_hold_valid", 32'(O_valid), 32'd1);
    I_ready = 1'b1;
    repeat (8) tick();
    check("bp_delivered", 32'(n_xfer), 32'd4);
    check("bp_last", 32'(exp_next), 32'h05);

    // Empty toggling every cycle with downstream ready
    do_reset();
    load(40);
    I_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      force_empty = (i % 2) != 0;
      tick();
    end
    check("toggle_pops", 32'(n_pop), 32'd20);
    check("toggle_delivered", 32'(n_xfer), 32'd19);

    // Random traffic against the model
    do_reset();
    occ_max = 0;
    ready_pct = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 1000 == 0) ready_pct = int'($urandom_range(10, 100));
      if (fifo_q.size() < 3) load(4);
      force_empty = ($urandom_range(0, 3) == 0);
      I_ready = ($urandom_range(0, 99) < ready_pct);
      tick();
    end
    check("rand_occ_max_le2", 32'(occ_max <= 2), 32'd1);
    check("rand_progress", 32'(n_xfer > 1000), 32'd1);
`ifdef FIFO_RD_CNT_EN
    check("rand_cnt", 32'(O_rd_cnt), 32'(xfer_total[15:0]));

    // Counter wrap: 65535 transfers, then one more
    do_reset();
    I_ready = 1'b1;
    for (int g = 0; g < 70000 && xfer_total < 65535; g++) begin
      if (fifo_q.size() < 3) load(8);
      tick();
    end
    check("wrap_preset", 32'(O_rd_cnt), 32'h0000FFFF);
    for (int g = 0; g < 10 && xfer_total < 65536; g++) begin
      if (fifo_q.size() < 3) load(8);
      tick();
    end
    check("wrap_total", 32'(xfer_total), 32'd65536);
    check("wrap_zero", 32'(O_rd_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
